// File: rtl/pipeline_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stall_ctrl_pkg
// Brief    : Shared state encodings and constants for the pipeline stall
//            sequencer and its load-use compare helper.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_stall_ctrl_pkg;

    // Sequencer states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BOOT    = 3'd1,
        ST_RUN     = 3'd2,
        ST_MEMWAIT = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    // Register specifier of the hard-wired zero register; a load into it
    // never creates a dependency, so it also serves as the NOP destination.
    localparam int REG_ZERO = 0;

    // Stall cycles are only accounted for while the pipeline is live
    function automatic logic counts_stall(input state_t s);
        return (s == ST_RUN) || (s == ST_MEMWAIT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_stall_ctrl_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module   : load_use_detect
// Brief    : Pure compare: flags when the instruction in ID consumes the
//            destination of a load still sitting in EX.
// Revision : 1.0 - initial release
// ============================================================================
module load_use_detect
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_use_rt,
    output logic             hazard
);

    logic dest_live;
    logic rs_match;
    logic rt_match;

    // A load into the zero register has no consumer; rt only matters when
    // the ID instruction actually reads it.
    always_comb begin
        dest_live = (idex_rt != REG_W'(REG_ZERO));
        rs_match  = (idex_rt == ifid_rs);
        rt_match  = ifid_use_rt && (idex_rt == ifid_rt);
        hazard    = idex_memread && dest_live && (rs_match || rt_match);
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stall_ctrl
// Brief    : Central stall/flush sequencer for the 5-stage pipeline. Drives
//            PC hold, IF/ID hold/flush, ID/EX bubble and back-end freeze,
//            sequencing boot, load-use bubbles, taken-branch flushes and
//            multi-cycle data-memory waits with a timeout into HALT.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int REG_W       = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             ifid_use_rt_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_start_o,
    output logic             pc_hold_o,
    output logic             ifid_hold_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_freeze_o,
    output logic             halt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

    state_t             state;
    logic   [TO_W-1:0]  tmo_cnt;
    logic               pc_start;
    logic               halt;
    logic   [CNT_W-1:0] stall_cnt;
    logic               load_use;
    logic               mem_stall;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .idex_memread (idex_memread_i),
        .idex_rt      (idex_rt_i),
        .ifid_rs      (ifid_rs_i),
        .ifid_rt      (ifid_rt_i),
        .ifid_use_rt  (ifid_use_rt_i),
        .hazard       (load_use)
    );

    // A request acknowledged in the same cycle completes without stalling
    assign mem_stall = mem_req_i && !mem_ack_i;

    // Sequencer: state, memory-wait timeout, boot pulse and sticky halt flag
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= ST_IDLE;
            tmo_cnt  <= '0;
            pc_start <= 1'b0;
            halt     <= 1'b0;
        end else begin
            pc_start <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state    <= ST_BOOT;
                        pc_start <= 1'b1;
                    end
                end
                ST_BOOT: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (mem_stall) begin
                        state   <= ST_MEMWAIT;
                        tmo_cnt <= TO_W'(1);
                    end
                end
                ST_MEMWAIT: begin
                    // The request cycle in RUN counts as the first waited cycle
                    if (mem_ack_i) begin
                        state <= ST_RUN;
                    end else if (tmo_cnt >= TO_W'(MEM_TIMEOUT - 1)) begin
                        state <= ST_HALT;
                        halt  <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TO_W'(1);
                    end
                end
                ST_HALT: begin
                    halt <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pipeline controls decoded from the current state and hazard inputs
    always_comb begin
        pc_hold_o     = 1'b0;
        ifid_hold_o   = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_freeze_o = 1'b0;
        unique case (state)
            ST_IDLE: begin
                pc_hold_o     = 1'b1;
                ifid_flush_o  = 1'b1;
                idex_bubble_o = 1'b1;
            end
            ST_BOOT: begin
                ifid_flush_o  = 1'b1;
                idex_bubble_o = 1'b1;
            end
            ST_RUN: begin
                if (mem_stall) begin
                    pc_hold_o     = 1'b1;
                    ifid_hold_o   = 1'b1;
                    pipe_freeze_o = 1'b1;
                end else if (load_use) begin
                    // The branch in ID is re-evaluated once the bubble clears
                    pc_hold_o     = 1'b1;
                    ifid_hold_o   = 1'b1;
                    idex_bubble_o = 1'b1;
                end else if (branch_taken_i) begin
                    ifid_flush_o  = 1'b1;
                end
            end
            ST_MEMWAIT, ST_HALT: begin
                pc_hold_o     = 1'b1;
                ifid_hold_o   = 1'b1;
                pipe_freeze_o = 1'b1;
            end
            default: begin
                pc_hold_o     = 1'b1;
                ifid_flush_o  = 1'b1;
                idex_bubble_o = 1'b1;
            end
        endcase
    end

    // Saturating count of PC-hold cycles while the pipeline is live
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
        end else if (counts_stall(state) && pc_hold_o && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign pc_start_o  = pc_start;
    assign halt_o      = halt;
    assign stall_cnt_o = stall_cnt;

endmodule
`default_nettype wire
